// File: rtl/pixel_sreg_seq_pkg.sv
// Shared widths, pair counts and state type for the pixel
// shift-register sequencer.
package pixel_sreg_seq_pkg;

  localparam int WORD_W = 42;
  localparam int PAIR_W = 2;
  localparam int NPAIRS = 21;
  localparam int CNT_W  = $clog2(NPAIRS);

  localparam logic [PAIR_W-1:0] FILL = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pixel_sreg_seq.sv
// Loads a 42-bit pixel word into an external 2-bit-wide scan chain
// and captures the word returning from the top of the chain.
module pixel_sreg_seq
  import pixel_sreg_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              flush,
  output logic              sreg_shift,
  output logic [WORD_W-1:0] sreg_pixel,
  output logic [PAIR_W-1:0] sreg_sin,
  input  logic [PAIR_W-1:0] sreg_sout,
  output logic              rx_valid,
  output logic [WORD_W-1:0] rx_data,
  output logic              busy
);

  localparam int SH_W = WORD_W - PAIR_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] pixel_q, pixel_d;
  logic [SH_W-1:0]   rx_sh_q, rx_sh_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              tx_ready_q, tx_ready_d;
  logic              shift_q, shift_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;
  logic              accept;

  assign accept = tx_valid && tx_ready_q && !flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pixel_d   = pixel_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    unique case (1'b1)
      (state_q == S_IDLE),
      (state_q == S_DONE): begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_LOAD;
          pixel_d = tx_data;
        end
      end
      (state_q == S_LOAD): begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      (state_q == S_SHIFT): begin
        rx_sh_d = {rx_sh_q[SH_W-PAIR_W-1:0], sreg_sout};
        if (cnt_q == CNT_W'(NPAIRS - 1)) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          rx_data_d = {rx_sh_q, sreg_sout};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a pending accept.
    if (flush) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      pixel_d   = pixel_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
    end
  end

  always_comb begin
    tx_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d     = (state_d == S_LOAD) || (state_d == S_SHIFT);
    shift_d    = (state_d == S_SHIFT);
    rx_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pixel_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b0;
      shift_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pixel_q    <= pixel_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      shift_q    <= shift_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign sreg_shift = shift_q;
  assign sreg_pixel = pixel_q;
  assign sreg_sin   = FILL;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;

endmodule

// File: doc/pixel_sreg_seq.md
PIXEL_SREG_SEQ -- requirements
Module: pixel_sreg_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: tx_valid  in  1  host offers word; tx_ready  out  1  sequencer accepts word.
REQ-004 SHALL have ports: tx_data  in  42  pixel word to load into chain.
REQ-005 SHALL have ports: flush  in  1  synchronous abort of current transaction.
REQ-006 SHALL have ports: sreg_shift  out  1  0 = parallel load, 1 = shift 2 bits/cycle.
REQ-007 SHALL have ports: sreg_pixel  out  42  parallel load value to chain.
REQ-008 SHALL have ports: sreg_sin  out  2  serial fill into chain LSBs; sreg_sout  in  2  chain top pair [41:40].
REQ-009 SHALL have ports: rx_valid  out  1  one-cycle pulse; rx_data  out  42  word captured from sreg_sout.
REQ-010 SHALL have ports: busy  out  1  high in LOAD or SHIFT.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, SHIFT, DONE; all outputs registered.
REQ-012 tx_ready SHALL be 1 in IDLE and DONE, 0 otherwise; accept = tx_valid && tx_ready at rising edge.
REQ-013 On accept, tx_data SHALL be latched and next state SHALL be LOAD; no accept -> IDLE (from IDLE or DONE).
REQ-014 LOAD (1 cycle): sreg_shift=0, sreg_pixel=latched word; next SHIFT, pair counter cleared to 0.
REQ-015 SHIFT: sreg_shift=1 for exactly NPAIRS=21 cycles; each edge SHALL capture sreg_sout into rx shifter (shift left 2, insert at [1:0]); counter increments 0..20.
REQ-016 At counter==20 edge SHALL go DONE; rx_data SHALL update with the 21-pair capture (first-captured pair at [41:40]).
REQ-017 DONE (1 cycle): rx_valid=1; rx_data held stable until next DONE.
REQ-018 Latency: accept edge E0 -> rx_valid high in cycle after edge E0+22; back-to-back period 23 cycles.
REQ-019 sreg_sin SHALL be constant FILL=2'b00 in all states.
REQ-020 sreg_pixel SHALL hold last latched word outside LOAD; 0 after reset.
REQ-021 flush in LOAD/SHIFT SHALL force IDLE next edge, sreg_shift=0, no rx_valid, rx_data unchanged.
REQ-022 flush in IDLE/DONE SHALL force IDLE and block acceptance that edge (flush beats tx_valid).
REQ-023 tx_valid while busy SHALL be ignored; tx_data changes while busy SHALL not affect sreg_pixel.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, counter=0, tx_ready=0, sreg_shift=0, sreg_pixel=0, sreg_sin=0, rx_valid=0, rx_data=0, busy=0.
REQ-025 Reset mid-SHIFT SHALL discard capture; first accept after release SHALL behave per REQ-013.
REQ-026 tx_ready SHALL rise in the first cycle after the first edge with rst_n high.

Structure
REQ-027 Shared package SHALL hold WORD_W=42, PAIR_W=2, NPAIRS=21, FILL, and the state enum type.
REQ-028 Counter width SHALL be $clog2(NPAIRS); no arithmetic overflow permitted past 20.
REQ-029 Single module, no sub-modules; rx capture shifter is inline.

Verification
REQ-030 Loopback with behavioural 42-bit chain (load on shift=0, shl 2 on shift=1, out=[41:0]'s [41:40]): tx_data=42'h26B4B5F692B -> rx_data=42'h26B4B5F692B, rx_valid 23 cycles after accept.
REQ-031 Back-to-back: tx_valid held high with words 42'h3FFFFFFFFFF then 42'h0 -> two rx_valid pulses 23 cycles apart, correct data each; tx_ready high only in IDLE/DONE.
REQ-032 flush asserted at SHIFT counter 10 -> IDLE next cycle, no rx_valid, rx_data retains prior value, sreg_shift=0.
REQ-033 rst_n dropped mid-SHIFT at counter 5 -> all outputs zero asynchronously; after release new word 42'h15555555555 loops back correctly.
REQ-034 tx_valid toggled and tx_data changed during SHIFT -> ignored, sreg_pixel unchanged, count of sreg_shift=1 cycles exactly 21.
